// File: rtl/pipe_last_sender.sv
// Length-prefixed to last-framed packetizer with a small egress FIFO.
// Optional packet counter output enabled by LAST_SENDER_STATS_EN.
module pipe_last_sender #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  in_enq__ENA,
    input  logic [DATA_WIDTH-1:0] in_enq_v,
    output logic                  in_enq__RDY,
    output logic                  out_enq__ENA,
    output logic [DATA_WIDTH-1:0] out_enq_v,
    output logic                  out_enq_last,
    input  logic                  out_enq__RDY,
    output logic                  busy
`ifdef LAST_SENDER_STATS_EN
    ,
    output logic [31:0]           pkt_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {HDR, DATA} state_t;

    state_t               state, state_nx;
    logic [LEN_WIDTH-1:0] remaining, remaining_nx, len;
    logic [PW-1:0]        wr_ptr, rd_ptr, count;
    logic [DATA_WIDTH:0]  mem [DEPTH];
    logic [DATA_WIDTH:0]  head;
    logic                 full, empty, in_fire, out_fire, wr_last;

    // Pointer MSB separates full from empty; difference is the fill level.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (count == '0);
    assign in_fire = in_enq__ENA && !full;
    assign out_fire = out_enq__ENA && out_enq__RDY;
    assign len     = in_enq_v[LEN_WIDTH-1:0];
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= HDR;
            remaining <= '0;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        if (in_fire) begin
            unique case (state)
                HDR: begin
                    if (len != '0) begin
                        state_nx     = DATA;
                        remaining_nx = len;
                    end
                end
                DATA: begin
                    remaining_nx = remaining - 1'b1;
                    if (remaining == LEN_WIDTH'(1))
                        state_nx = HDR;
                end
                default: state_nx = HDR;
            endcase
        end
    end

    always_comb begin
        wr_last = 1'b0;
        unique case (state)
            HDR:     wr_last = (len == '0);
            DATA:    wr_last = (remaining == LEN_WIDTH'(1));
            default: wr_last = 1'b0;
        endcase
        in_enq__RDY  = !full;
        out_enq__ENA = !empty;
        out_enq_v    = empty ? '0 : head[DATA_WIDTH-1:0];
        out_enq_last = empty ? 1'b0 : head[DATA_WIDTH];
        busy         = !empty || (state == DATA);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (out_fire)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (in_fire)
            mem[wr_ptr[AW-1:0]] <= {wr_last, in_enq_v};
    end

`ifdef LAST_SENDER_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pkt_count <= '0;
        else if (out_fire && out_enq_last)
            pkt_count <= pkt_count + 32'd1;
    end
`endif

endmodule
